// File: rtl/flptadder_asm_normalizer_if.sv
// Handshake/bus bundle between the significand adder, the normalize/pack
// stage (flptadder_asm_normalizer) and the result consumer.
interface flptadder_asm_normalizer_if;
  localparam int unsigned EXP_W = 5;
  localparam int unsigned SUM_W = 6;
  localparam int unsigned Z_W   = 10;

  logic             in_valid;
  logic             in_ready;
  logic             sign_in;
  logic [EXP_W-1:0] exp_in;
  logic [SUM_W-1:0] sum_in;
  logic             out_valid;
  logic             out_ready;
  logic [Z_W-1:0]   z;
  logic             ovf;
  logic             unf;

  // Normalizer side
  modport slave (
    input  in_valid, sign_in, exp_in, sum_in, out_ready,
    output in_ready, out_valid, z, ovf, unf
  );

  // Producer/consumer side
  modport master (
    output in_valid, sign_in, exp_in, sum_in, out_ready,
    input  in_ready, out_valid, z, ovf, unf
  );
endinterface

// File: rtl/flptadder_asm_normalizer.sv
// Post-add normalize/pack stage of the 10-bit float adder ASM.
// Renormalizes the raw 6-bit significand sum one shift per cycle, then packs
// {sign, exp[4:0], frac[3:0]} with overflow / flush-to-zero flags.
// Optional macro FLPTNORM_ROUND_EN: round-half-up on right shifts
// (default build truncates).
module flptadder_asm_normalizer (
  input  logic                        clk,
  input  logic                        rst_n,
  flptadder_asm_normalizer_if.slave   bus,
  output logic                        busy
);

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned SUM_W  = 6;
  localparam int unsigned EXPI_W = 7;
  localparam int unsigned Z_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    mant_q, mant_d;
  logic signed [EXPI_W-1:0] exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [Z_W-1:0]      z_q, z_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      z_q         <= z_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, one normalization step per cycle, and pack on NORM->DONE
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sign_d  = bus.sign_in;
          exp_d   = EXPI_W'({2'b00, bus.exp_in});
          mant_d  = bus.sum_in;
          state_d = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          // Exact cancellation: signed zero, no flags
          z_d     = {sign_q, 9'b0};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = DONE;
        end else if (mant_q[5]) begin
          // Carry-out: shift right; a rounding re-carry loops once more
`ifdef FLPTNORM_ROUND_EN
          mant_d = (mant_q >> 1) + SUM_W'(mant_q[0]);
`else
          mant_d = mant_q >> 1;
`endif
          exp_d  = exp_q + 7'sd1;
        end else if (mant_q[4]) begin
          // Hidden 1 in place: pack with range checks
          if (exp_q >= 7'sd31) begin
            z_d   = {sign_q, 5'h1F, 4'h0};
            ovf_d = 1'b1;
            unf_d = 1'b0;
          end else if (exp_q <= 7'sd0) begin
            z_d   = {sign_q, 9'b0};
            ovf_d = 1'b0;
            unf_d = 1'b1;
          end else begin
            z_d   = {sign_q, exp_q[EXP_W-1:0], mant_q[3:0]};
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
          state_d = DONE;
        end else begin
          // Leading zero: shift left; a nonzero mant reaches bit 4 in <=4 steps
          mant_d = mant_q << 1;
          exp_d  = exp_q - 7'sd1;
        end
      end

      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_flptadder_asm_normalizer.sv
// Directed, table-driven bench for flptadder_asm_normalizer plus hand-written
// backpressure and mid-operation reset sequences.
module tb_flptadder_asm_normalizer;

  logic clk;
  logic rst_n;
  logic busy;

  flptadder_asm_normalizer_if bus ();

  flptadder_asm_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sign;
    logic [4:0] exp;
    logic [5:0] sum;
    logic [9:0] z;
    logic       ovf;
    logic       unf;
    int         lat;   // first out_valid cycle, counted as T+lat from accept
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int tests;
  int fails;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set and return the number of edges after the accept
  // edge until out_valid rises (bounded).
  task automatic launch(input logic s, input logic [4:0] e, input logic [5:0] m,
                        output int edges);
    bus.sign_in  = s;
    bus.exp_in   = e;
    bus.sum_in   = m;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    logic [9:0] held;

    tests = 0;
    fails = 0;

    vecs[0]  = '{1'b0, 5'd10, 6'b010110, 10'h0A6, 1'b0, 1'b0, 2};
`ifdef FLPTNORM_ROUND_EN
    vecs[1]  = '{1'b0, 5'd10, 6'b101101, 10'h0B7, 1'b0, 1'b0, 3};
`else
    vecs[1]  = '{1'b0, 5'd10, 6'b101101, 10'h0B6, 1'b0, 1'b0, 3};
`endif
    vecs[2]  = '{1'b0, 5'd10, 6'b000011, 10'h078, 1'b0, 1'b0, 5};
    vecs[3]  = '{1'b1, 5'd17, 6'b000000, 10'h200, 1'b0, 1'b0, 2};
    vecs[4]  = '{1'b0, 5'd30, 6'b100000, 10'h1F0, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b0, 5'd3,  6'b000001, 10'h000, 1'b0, 1'b1, 6};
    vecs[6]  = '{1'b0, 5'd31, 6'b010000, 10'h1F0, 1'b1, 1'b0, 2};
    vecs[7]  = '{1'b1, 5'd0,  6'b011000, 10'h200, 1'b0, 1'b1, 2};
`ifdef FLPTNORM_ROUND_EN
    vecs[8]  = '{1'b0, 5'd5,  6'b111111, 10'h070, 1'b0, 1'b0, 4};
`else
    vecs[8]  = '{1'b0, 5'd5,  6'b111111, 10'h06F, 1'b0, 1'b0, 3};
`endif
    vecs[9]  = '{1'b1, 5'd1,  6'b001000, 10'h200, 1'b0, 1'b1, 3};
    vecs[10] = '{1'b0, 5'd30, 6'b010001, 10'h1E1, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b1, 5'd1,  6'b010101, 10'h215, 1'b0, 1'b0, 2};
`ifdef FLPTNORM_ROUND_EN
    vecs[12] = '{1'b0, 5'd10, 6'b100001, 10'h0B1, 1'b0, 1'b0, 3};
`else
    vecs[12] = '{1'b0, 5'd10, 6'b100001, 10'h0B0, 1'b0, 1'b0, 3};
`endif

    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = '0;
    bus.sum_in    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_z",         int'(bus.z),         0);
    check("rst_ovf",       int'(bus.ovf),       0);
    check("rst_unf",       int'(bus.unf),       0);
    check("rst_busy",      int'(busy),          0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("v%0d_in_ready", i), int'(bus.in_ready), 1);
      launch(vecs[i].sign, vecs[i].exp, vecs[i].sum, edges);
      check($sformatf("v%0d_latency", i), edges + 1, vecs[i].lat);
      check($sformatf("v%0d_z", i),   int'(bus.z),   int'(vecs[i].z));
      check($sformatf("v%0d_ovf", i), int'(bus.ovf), int'(vecs[i].ovf));
      check($sformatf("v%0d_unf", i), int'(bus.unf), int'(vecs[i].unf));
      check($sformatf("v%0d_done_in_ready", i), int'(bus.in_ready), 0);
      tick();
      check($sformatf("v%0d_idle_out_valid", i), int'(bus.out_valid), 0);
    end

    // Backpressure: result held stable in DONE while out_ready is low
    bus.out_ready = 1'b0;
    launch(1'b0, 5'd10, 6'b010110, edges);
    check("bp_latency", edges + 1, 2);
    held = bus.z;
    check("bp_z_first", int'(held), 10'h0A6);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp%0d_z", k),         int'(bus.z),         10'h0A6);
      check($sformatf("bp%0d_out_valid", k), int'(bus.out_valid), 1);
      check($sformatf("bp%0d_in_ready", k),  int'(bus.in_ready),  0);
      check($sformatf("bp%0d_busy", k),      int'(busy),          1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_rel_out_valid", int'(bus.out_valid), 0);
    check("bp_rel_in_ready",  int'(bus.in_ready),  1);
    check("bp_rel_busy",      int'(busy),          0);

    // Reset asserted mid-NORM aborts immediately
    bus.sign_in  = 1'b0;
    bus.exp_in   = 5'd3;
    bus.sum_in   = 6'b000001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mid_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_in_ready",  int'(bus.in_ready),  1);
    check("mid_rst_busy",      int'(busy),          0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", int'(bus.out_valid), 0);

    // Clean operation after abort
    launch(1'b0, 5'd10, 6'b000011, edges);
    check("post_rst_latency", edges + 1, 5);
    check("post_rst_z", int'(bus.z), 10'h078);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flptadder_asm_normalizer.md
# flptadder_asm_normalizer

Post-add normalize/pack stage of the 10-bit floating-point adder ASM. It sits directly downstream of the 5-bit fixed-point significand adder and consumes that adder's 6-bit raw sum together with the aligned exponent and result sign. It renormalizes the significand one shift per cycle. It then packs the 10-bit result (1 sign, 5 biased exponent, 4 fraction, hidden 1) with overflow/underflow flags behind a valid/ready handshake.

## Interface
Parameters:
- none; the format is fixed at sign[9], exp[8:4], frac[3:0].

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sum/exponent/sign valid
- in_ready  out  1  block can accept; high only in IDLE
- sign_in  in  1  result sign
- exp_in  in  5  biased exponent of the aligned operands
- sum_in  in  6  raw significand sum; bit 5 is adder carry-out, bit 4 is hidden-1 position
- out_valid  out  1  packed result valid
- out_ready  in  1  downstream accepts result
- z  out  10  packed float result
- ovf  out  1  exponent overflow; qualified by out_valid
- unf  out  1  underflow flush-to-zero; qualified by out_valid
- busy  out  1  high in NORM or DONE

## Operation
- Internal registers:
  - mant[5:0]
  - exp: 7-bit signed, zero-extended from exp_in
  - sign
- FSM states: IDLE, NORM, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, capture sign_in, exp_in and sum_in, then go to NORM.
- NORM evaluates one case per cycle, in priority order:
  - mant==0: pack a signed zero {sign,9'b0}, ovf=0, unf=0, go to DONE.
  - mant[5]==1: mant<=mant>>1, exp<=exp+1, stay in NORM. Rounding follows Configuration.
  - mant[4]==1: pack, go to DONE.
  - Otherwise: mant<=mant<<1, exp<=exp-1, stay in NORM.
- Pack rules, applied to the z/ovf/unf registers on the NORM→DONE transition:
  - exp>=31: z={sign,5'h1F,4'h0}, ovf=1.
  - exp<=0: z={sign,9'b0}, unf=1.
  - Otherwise: z={sign,exp[4:0],mant[3:0]}.
- DONE: out_valid=1. z, ovf and unf hold stable until out_ready. When out_valid&&out_ready, go to IDLE. There is no same-cycle re-accept; in_ready stays 0 in DONE.
- Input exp_in=0 with a nonzero sum is legal. It normalizes and typically flushes via the unf path.
- The left-shift loop is bounded at 4 iterations, because mant!=0 guarantees that a set bit reaches bit 4.

## Timing
- Reset (async, rst_n low):
  - state=IDLE, so in_ready=1.
  - out_valid=0, z=0, ovf=0, unf=0, busy=0.
  - mant/exp/sign cleared.
- Reset asserted mid-NORM or mid-DONE aborts the operation. No output handshake occurs.
- Latency is counted from the accept edge T to the first cycle out_valid is high:
  - already normalized or zero: T+2
  - right shift: T+3, or T+4 if rounding re-carries
  - n left shifts (n=1..4): T+2+n
- Maximum occupancy is 6 cycles plus backpressure.
- Throughput: one result per (latency + 1) cycles at best. DONE spends at least 1 cycle and IDLE spends 1 cycle.

## Configuration
- Macro: FLPTNORM_ROUND_EN
- Defined: on a right shift, the dropped bit mant[0] is added, i.e. round-half-up: mant<=(mant>>1)+mant[0]. If the result sets mant[5] (input 6'b111111), NORM performs a second right shift on the next cycle.
- Undefined: right shift truncates, mant<=mant>>1. At most one right shift ever occurs.

## Test plan
- Normalized: sum_in=6'b010110, exp_in=10, sign_in=0 -> z=10'h0A6, ovf=0, unf=0, out_valid at T+2.
- Carry-out: sum_in=6'b101101, exp_in=10 -> without macro z=10'h0B6 at T+3. With FLPTNORM_ROUND_EN, z=10'h0B7 at T+3.
- Left shifts: sum_in=6'b000011, exp_in=10 -> z=10'h078 (exp 7, frac 1000) at T+5.
- Zero: sum_in=0, sign_in=1, exp_in=17 -> z=10'h200 at T+2.
- Overflow and underflow:
  - sum_in=6'b100000, exp_in=30 -> z=10'h1F0, ovf=1.
  - sum_in=6'b000001, exp_in=3 -> z=10'h000, unf=1 at T+6.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> z stable, in_ready=0, busy=1. Then out_ready=1 -> IDLE next cycle.
  - Drop rst_n during NORM -> out_valid=0 and in_ready=1 immediately.
